modular_half_pipe: RTL and testbench

//  Multi-lane iterative modular halving unit: computes y = x * 2^-k mod Q on LANES coefficients per transaction.
//  k is supplied with the data; one halving step is applied per clock.

---
 rtl/modular_half_pkg.sv | 20 ++
 rtl/modular_half_lane.sv | 22 ++
 rtl/modular_half_pipe.sv | 115 +++++++++++
 tb/tb_modular_half_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/modular_half_pkg.sv
// Shared constants and types for the multi-lane modular halving unit.
package modular_half_pkg;

   localparam int unsigned DEFAULT_DATA_W = 12;
   localparam int unsigned DEFAULT_Q      = 3329;

   // (Q+1)/2 is the inverse of 2 mod an odd Q.
   function automatic int unsigned q_half(input int unsigned q);
      return (q + 1) / 2;
   endfunction

   localparam int unsigned DEFAULT_Q_HALF = q_half(DEFAULT_Q);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } half_state_e;

endpackage

// File: rtl/modular_half_lane.sv
// Combinational single modular halving step: y = x * 2^-1 mod Q, for x < Q.
module modular_half_lane
   import modular_half_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned Q      = DEFAULT_Q
) (
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);

   localparam logic [DATA_W-1:0] QHalfW = DATA_W'(q_half(Q));

   // Odd x: (x-1)/2 + (Q+1)/2 = (x+Q)/2. The sum is at most Q-1, so DATA_W bits suffice.
   always_comb begin
      y = {1'b0, x[DATA_W-1:1]};
      if (x[0]) begin
         y = y + QHalfW;
      end
   end

endmodule

// File: rtl/modular_half_pipe.sv
// Multi-lane iterative modular halving: y = x * 2^-k mod Q, one halving per clock.
// Optional build macro MODHALF_REDUCE_IN_EN: conditionally subtract Q from each lane at load
// so inputs up to 2Q-1 are accepted.
module modular_half_pipe
   import modular_half_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned Q       = DEFAULT_Q,
   parameter int unsigned LANES   = 2,
   parameter int unsigned SHIFT_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [SHIFT_W-1:0]      in_shift,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    busy
);

   half_state_e               state_q, state_d;
   logic [SHIFT_W-1:0]        cnt_q;
   logic [LANES*DATA_W-1:0]   lanes_q;
   logic [LANES*DATA_W-1:0]   stepped;
   logic [LANES*DATA_W-1:0]   load_data;
   logic                      accept;

   assign accept = in_valid && in_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      modular_half_lane #(
         .DATA_W (DATA_W),
         .Q      (Q)
      ) u_lane (
         .x (lanes_q[i*DATA_W +: DATA_W]),
         .y (stepped[i*DATA_W +: DATA_W])
      );

`ifdef MODHALF_REDUCE_IN_EN
      localparam logic [DATA_W-1:0] QW = DATA_W'(Q);
      // Single conditional subtract; correct for x < 2Q.
      always_comb begin
         load_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
         if (in_data[i*DATA_W +: DATA_W] >= QW) begin
            load_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W] - QW;
         end
      end
`else
      assign load_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a DONE handshake with a simultaneous accept reloads without passing IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (in_shift == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (cnt_q == SHIFT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               if (accept) begin
                  state_d = (in_shift == '0) ? StDone : StRun;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
   end

   // Lane registers and shift counter: load on accept, halve once per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes_q <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         lanes_q <= load_data;
         cnt_q   <= in_shift;
      end else if (state_q == StRun) begin
         lanes_q <= stepped;
         cnt_q   <= cnt_q - SHIFT_W'(1);
      end
   end

   assign out_data = lanes_q;

endmodule

// File: tb/tb_modular_half_pipe.sv
// Directed self-checking bench for modular_half_pipe (Q=3329, LANES=2, SHIFT_W=4).
module tb_modular_half_pipe;

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned LANES   = 2;
   localparam int unsigned SHIFT_W = 4;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_data;
   logic [SHIFT_W-1:0]      in_shift;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*DATA_W-1:0] out_data;
   logic                    busy;

   int n_checks = 0;
   int n_fail   = 0;

   modular_half_pipe #(
      .DATA_W  (DATA_W),
      .Q       (3329),
      .LANES   (LANES),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction from IDLE: checks latency, both result lanes, then drains.
   task automatic run_txn(input string tag, input int k, input int a, input int b,
                          input int ea, input int eb);
      int cycles;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_shift = SHIFT_W'(k);
      in_data  = {DATA_W'(b), DATA_W'(a)};
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      cycles = 1;
      while (!out_valid && cycles < 40) begin
         tick();
         cycles++;
      end
      check({tag, " latency"}, 32'(cycles), 32'(k + 1));
      check({tag, " lane0"}, 32'(out_data[DATA_W-1:0]), 32'(ea));
      check({tag, " lane1"}, 32'(out_data[2*DATA_W-1:DATA_W]), 32'(eb));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " drained"}, {30'd0, out_valid, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LANES*DATA_W-1:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shift  = '0;
      out_ready = 1'b0;
      #23;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Basic halving and boundary values.
      run_txn("k1 a", 1, 1, 2, 1665, 1);
      run_txn("k1 b", 1, 3328, 0, 1664, 0);
      run_txn("k2", 2, 1, 1665, 2497, 2913);
      run_txn("k8", 8, 1, 1234, 3316, 603);
      run_txn("k0", 0, 1234, 0, 1234, 0);
      run_txn("k15", 15, 1, 3328, 338, 2991);

      // Back-to-back: DONE handshake and next accept share an edge.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_shift  = SHIFT_W'(1);
      in_data   = {DATA_W'(2), DATA_W'(1)};
      tick();
      in_data   = {DATA_W'(0), DATA_W'(3328)};
      tick();
      check("b2b first valid", 32'(out_valid), 32'd1);
      check("b2b in_ready at done", 32'(in_ready), 32'd1);
      check("b2b first data", 32'(out_data), 32'({DATA_W'(1), DATA_W'(1665)}));
      tick();
      in_valid = 1'b0;
      check("b2b reload run", {30'd0, out_valid, busy}, 32'd1);
      tick();
      check("b2b second valid", 32'(out_valid), 32'd1);
      check("b2b second data", 32'(out_data), 32'({DATA_W'(0), DATA_W'(1664)}));
      tick();
      check("b2b idle", {30'd0, out_valid, busy}, 32'd0);
      out_ready = 1'b0;

      // Backpressure: result held for 5 cycles, new offers ignored.
      in_valid = 1'b1;
      in_shift = SHIFT_W'(2);
      in_data  = {DATA_W'(1665), DATA_W'(1)};
      tick();
      in_data  = {DATA_W'(7), DATA_W'(9)};
      tick();
      tick();
      held = out_data;
      check("bp data", 32'(held), 32'({DATA_W'(2913), DATA_W'(2497)}));
      for (int i = 0; i < 5; i++) begin
         check("bp valid held", 32'(out_valid), 32'd1);
         check("bp in_ready low", 32'(in_ready), 32'd0);
         check("bp data stable", 32'(out_data), 32'(held));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp single handshake", {30'd0, out_valid, busy}, 32'd0);
      tick();
      check("bp stays idle", {30'd0, out_valid, busy}, 32'd0);
      out_ready = 1'b0;

      // Reset mid-RUN discards the in-flight transaction.
      in_valid = 1'b1;
      in_shift = SHIFT_W'(8);
      in_data  = {DATA_W'(1), DATA_W'(1)};
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 32'(out_valid), 32'd0);
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset out_data", 32'(out_data), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      run_txn("after reset", 8, 1, 1234, 3316, 603);

`ifdef MODHALF_REDUCE_IN_EN
      run_txn("reduce", 1, 3330, 4000, 1665, 2000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
